// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared constants for the BCD 7-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Segment bit order {g,f,e,d,c,b,a}: bit 0 = a, bit 6 = g; 1 = lit.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b0111111;
  localparam seg_t SEG_1     = 7'b0000110;
  localparam seg_t SEG_2     = 7'b1011011;
  localparam seg_t SEG_3     = 7'b1001111;
  localparam seg_t SEG_4     = 7'b1100110;
  localparam seg_t SEG_5     = 7'b1101101;
  localparam seg_t SEG_6     = 7'b1111101;
  localparam seg_t SEG_7     = 7'b0000111;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1101111;
  localparam seg_t SEG_DASH  = 7'b1000000;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_7seg
// Purpose  : Nibble to active-high 7-segment pattern; non-BCD nibbles show a dash.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] nibble,
  input  logic                   blank,
  output seg_t                   seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : bcd_7seg_scan
// Purpose  : Double-buffered, time-multiplexed common-anode 7-segment driver.
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_7seg_scan
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd,
  input  logic                              bcd_valid,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             an,
  output logic                              frame_tick
);

  localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       C_SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [DIV_W-1:0]      div_cnt_q,   div_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [BCD_W-1:0]      shadow_q,    shadow_d;
  logic [BCD_W-1:0]      disp_q,      disp_d;
  logic                  pending_q,   pending_d;
  logic [6:0]            seg_q,       seg_d;
  logic [NUM_DIGITS-1:0] an_q,        an_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                   tick;
  logic                   boundary;
  logic [BCD_DIGIT_W-1:0] digit_nib;
  logic                   digit_blank;
  seg_t                   seg_pat;

  always_comb begin
    tick         = (div_cnt_q == C_DIV_LAST);
    boundary     = tick && (digit_idx_q == C_IDX_LAST);
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    digit_idx_d  = digit_idx_q;
    if (tick) begin
      digit_idx_d = (digit_idx_q == C_IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    end
    shadow_d     = bcd_valid ? bcd : shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    // The boundary transfers the old shadow; a coincident strobe re-arms pending.
    if (boundary && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (bcd_valid) begin
      pending_d = 1'b1;
    end
    frame_tick_d = boundary;
  end

  always_comb begin
    digit_nib   = '0;
    digit_blank = 1'b0;
    an_d        = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        digit_nib = disp_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        an_d[i]   = 1'b0;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every more significant one are zero.
    digit_blank = (digit_idx_q != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= digit_idx_q) && (disp_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0)) begin
        digit_blank = 1'b0;
      end
    end
`endif
  end

  bcd_to_7seg u_dec (
    .nibble (digit_nib),
    .blank  (digit_blank),
    .seg    (seg_pat)
  );

  always_comb begin
    seg_d = seg_pat ^ {7{SEG_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      digit_idx_q  <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      seg_q        <= C_SEG_OFF;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_7seg_scan
// Purpose  : Directed self-checking bench, 3 digits, divide-by-4, active-low seg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_7seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bcd = '0;
  logic        bcd_valid = 1'b0;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  bit          st_en  [12];
  logic [11:0] st_val [12];

  typedef struct {
    string       name;
    logic [11:0] val;
    logic [6:0]  s0, s1, s2;
  } vec_t;

  vec_t vecs [7];

  localparam logic [6:0] S_ZERO = 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] S_ZUP = 7'b1111111;
`else
  localparam logic [6:0] S_ZUP = 7'b1000000;
`endif

  bcd_7seg_scan #(
    .NUM_DIGITS     (3),
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd        (bcd),
    .bcd_valid  (bcd_valid),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 12; i++) begin
      st_en[i]  = 1'b0;
      st_val[i] = '0;
    end
  endtask

  // One 12-cycle frame from its first cycle; slot s drives stimulus for posedge s+1.
  task automatic run_frame(input string nm, input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2);
    logic [6:0] es [3];
    logic [2:0] ea;
    es[0] = e0;
    es[1] = e1;
    es[2] = e2;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      ea = ~(3'b001 << (s / 4));
      chk({nm, " an"}, {4'b0, an}, {4'b0, ea});
      chk({nm, " seg"}, seg, es[s/4]);
      chk({nm, " frame_tick"}, {6'b0, frame_tick}, {6'b0, (s == 11)});
      bcd_valid = st_en[s];
      if (st_en[s]) bcd = st_val[s];
    end
  endtask

  initial begin
    vecs[0] = '{"v255", 12'h255, 7'b0010010, 7'b0010010, 7'b0100100};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[1] = '{"v0A3", 12'h0A3, 7'b0110000, 7'b0111111, 7'b1111111};
    vecs[2] = '{"v007", 12'h007, 7'b1111000, 7'b1111111, 7'b1111111};
    vecs[3] = '{"v000", 12'h000, 7'b1000000, 7'b1111111, 7'b1111111};
    vecs[4] = '{"v0A0", 12'h0A0, 7'b1000000, 7'b0111111, 7'b1111111};
`else
    vecs[1] = '{"v0A3", 12'h0A3, 7'b0110000, 7'b0111111, 7'b1000000};
    vecs[2] = '{"v007", 12'h007, 7'b1111000, 7'b1000000, 7'b1000000};
    vecs[3] = '{"v000", 12'h000, 7'b1000000, 7'b1000000, 7'b1000000};
    vecs[4] = '{"v0A0", 12'h0A0, 7'b1000000, 7'b0111111, 7'b1000000};
`endif
    vecs[5] = '{"v189", 12'h189, 7'b0010000, 7'b0000000, 7'b1111001};
    vecs[6] = '{"vF46", 12'hF46, 7'b0000010, 7'b0011001, 7'b0111111};

    // Reset held low
    repeat (3) @(negedge clk);
    chk("reset an", {4'b0, an}, 7'b0000111);
    chk("reset seg", seg, 7'b1111111);
    chk("reset frame_tick", {6'b0, frame_tick}, 7'b0);
    rst_n = 1'b1;

    clear_stim();
    run_frame("first", S_ZERO, S_ZUP, S_ZUP);

    // Mid-frame strobe must not show until the boundary
    clear_stim();
    st_en[5] = 1'b1; st_val[5] = vecs[0].val;
    run_frame("hold", S_ZERO, S_ZUP, S_ZUP);

    for (int i = 0; i < 7; i++) begin
      clear_stim();
      if (i < 6) begin
        st_en[3] = 1'b1; st_val[3] = vecs[i+1].val;
      end else begin
        st_en[2]  = 1'b1; st_val[2]  = 12'h111;
        st_en[6]  = 1'b1; st_val[6]  = 12'h999;
        st_en[10] = 1'b1; st_val[10] = 12'h321;
      end
      run_frame(vecs[i].name, vecs[i].s0, vecs[i].s1, vecs[i].s2);
    end

    clear_stim();
    run_frame("last_wins", 7'b0010000, 7'b0010000, 7'b0010000);
    run_frame("coincident", 7'b1111001, 7'b0100100, 7'b0110000);
    run_frame("stable", 7'b1111001, 7'b0100100, 7'b0110000);

    // Asynchronous reset mid-frame with a pending value
    @(negedge clk);
    bcd = 12'h777;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async an", {4'b0, an}, 7'b0000111);
    chk("async seg", seg, 7'b1111111);
    chk("async frame_tick", {6'b0, frame_tick}, 7'b0);
    repeat (2) @(negedge clk);
    chk("held an", {4'b0, an}, 7'b0000111);
    rst_n = 1'b1;
    run_frame("restart", S_ZERO, S_ZUP, S_ZUP);
    run_frame("discarded", S_ZERO, S_ZUP, S_ZUP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_7seg_scan.md
Name: bcd_7seg_scan

Overview:
Consumes the packed BCD word produced by the binary-to-BCD stage and drives a time-multiplexed common-anode 7-segment display, one digit at a time.
- Input value is double-buffered: a new value is displayed only at a frame boundary, so no digit tears.
- Sits between the binary-to-BCD converter and the board display pins.

Parameters:
NUM_DIGITS, 3, number of BCD digits and display positions (1..8).
REFRESH_DIV, 1000, clock cycles each digit is held (>=1).
SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (lit segment = 0); 0 = lit segment = 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
bcd  in  4*NUM_DIGITS  packed BCD; bcd[3:0] = least significant digit.
bcd_valid  in  1  single-cycle strobe; capture bcd into the shadow register.
seg  out  7  segment drive {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
an  out  NUM_DIGITS  digit enables, active-low one-hot; an[0] = least significant digit.
frame_tick  out  1  one-cycle pulse when a full scan frame completes.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: div_cnt=0, digit_idx=0, shadow=0, disp=0, pending=0, an=all 1s, seg=all segments off (polarity-correct), frame_tick=0. Assertion mid-scan forces these values immediately.
- Prescaler: div_cnt counts 0..REFRESH_DIV-1, then wraps. tick = (div_cnt==REFRESH_DIV-1). REFRESH_DIV=1 gives tick every cycle.
- On tick: digit_idx increments and wraps from NUM_DIGITS-1 to 0.
- Frame boundary = tick with digit_idx==NUM_DIGITS-1. At the boundary:
  - If pending is set: disp <= shadow and pending clears.
  - frame_tick=1 for the following cycle only.
- Capture: bcd_valid=1 loads shadow<=bcd and sets pending. Last strobe before a boundary wins.
- bcd_valid coincident with a boundary: disp takes the old shadow, shadow takes the new bcd, pending stays 1. The new value shows one frame later.
- Outputs are registered and driven from digit_idx and disp every cycle. Output latency is 1 cycle after the digit_idx change, including the first cycle after reset release (digit 0).
- Exactly one an bit is low outside reset.
- Decode, active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Nibble 10..15 shows dash 1000000.
  - Blank = 0000000.
  - SEG_ACTIVE_LOW=1 inverts the decoded pattern.

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined: digit i (i>0) is blanked when disp digits i..NUM_DIGITS-1 are all zero. An invalid nibble counts as nonzero. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all digits are always shown, including leading zeros.
- Scan timing and an behaviour are identical in both builds.

Decomposition:
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4.
  - seg pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (active-high).
  - Segment bit-order comment.
- Sub-module bcd_to_7seg: combinational nibble -> 7-bit active-high pattern, with a blank input. Instantiate once on the selected digit.

Test Plan:
All tests use NUM_DIGITS=3, REFRESH_DIV=4, SEG_ACTIVE_LOW=1.
1. Reset held low: an=111, seg=1111111, frame_tick=0. Release: next cycle an=110, seg=1000000 ("0"); digit advances every 4 cycles; frame_tick pulses every 12 cycles.
2. bcd=12'h255 strobed mid-frame: display is unchanged until frame_tick. The next frame shows an=110 seg=0010010, an=101 seg=0010010, an=011 seg=0100100.
3. bcd=12'h0A3: digit1 shows seg=0111111 (dash), digit0 shows 0110000, digit2 shows 1000000.
4. Two strobes in one frame (12'h111 then 12'h999), plus a strobe coincident with the boundary: only 12'h999 is displayed next frame. The coincident value appears the frame after that.
5. Built with LEADING_ZERO_BLANK_EN, bcd=12'h007: digits 2 and 1 show seg=1111111, digit0 shows 1111000. bcd=12'h000: only digit0 is lit, showing 1000000. bcd=12'h0A0: digit1 shows dash, digit2 is blank.
6. rst_n pulsed low mid-frame with a pending value: outputs go inactive asynchronously. The pending value is discarded and the display restarts at digit 0 showing 000.
